mem_port_arbiter: RTL and testbench

Shares the CPU's single memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage). It sequences one outstanding access at a time, returns read data to the owning requester, and generates `mem_stall` for the hazard unit. It also discards fetches killed by a flush and bounds every access with a timeout so the pipeline cannot hang.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and data access: one access in flight,
// data has priority, killed fetches are swallowed and every access is bounded by a timeout.
//
// state  | meaning
// IDLE   | no access in flight; grants d_req, else if_req
// D_WAIT | data access on the bus, waiting for mem_ready or timeout
// I_WAIT | fetch access on the bus, waiting for mem_ready or timeout
// RESP   | one-cycle response slot; owner's valid is high, no new grant
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              mem_stall,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic              kill;
    logic [CNT_W-1:0]  cnt;
    logic              finish;
    logic [DATA_W-1:0] cap_data;

    // An access ends either on mem_ready or on the last allowed wait cycle; a timeout returns zero.
    always_comb begin
        finish   = mem_ready | (cnt >= CNT_LAST);
        cap_data = mem_ready ? mem_rdata : '0;
    end

    assign mem_stall = (d_req & ~d_valid) | (if_req & ~if_valid & ~if_kill);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kill      <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            mem_err  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (d_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= D_WAIT;
                    end else if (if_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        state    <= I_WAIT;
                    end
                end

                D_WAIT, I_WAIT: begin
                    if (state == I_WAIT && if_kill) begin
                        kill <= 1'b1;
                    end
                    if (finish) begin
                        mem_req <= 1'b0;
                        mem_err <= ~mem_ready;
                        state   <= RESP;
                        if (!mem_ready) begin
                            cnt <= CNT_MAX;
                        end
                        if (state == D_WAIT) begin
                            d_rdata <= cap_data;
                            d_valid <= 1'b1;
                        end else begin
                            // A kill arriving with mem_ready still suppresses this fetch.
                            if_rdata <= cap_data;
                            if_valid <= ~(kill | if_kill);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    kill  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses into a scoreboard,
// a negedge monitor pops and compares whenever a valid or mem_err appears.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_kill, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_ready, mem_stall, mem_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: every valid or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (d_valid || if_valid || mem_err)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: d_valid=%b if_valid=%b mem_err=%b expected no response",
                         d_valid, if_valid, mem_err);
            end else begin
                mon_e = sb.pop_front();
                check1({mon_e.name, "_d_valid"}, d_valid, mon_e.is_d);
                check1({mon_e.name, "_if_valid"}, if_valid, !mon_e.is_d);
                check1({mon_e.name, "_mem_err"}, mem_err, mon_e.err);
                if (mon_e.chk_data)
                    check({mon_e.name, "_rdata"}, mon_e.is_d ? d_rdata : if_rdata, mon_e.data);
            end
        end
    end

    // Returns at the negedge of the first cycle with mem_req high; lat counts negedges waited.
    task automatic wait_mem_req(input string name, output int lat);
        lat = 0;
        @(negedge clk);
        while (mem_req !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (mem_req !== 1'b1) begin
            expire({name, "_mem_req"});
            lat = -1;
        end
    endtask

    // Acts as the memory: checks the request, holds ready low for waits cycles, then completes.
    task automatic serve(input int waits, input logic [31:0] rdata, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name,
                         output int lat);
        wait_mem_req(name, lat);
        if (lat < 0) return;
        check1({name, "_mem_we"}, mem_we, we);
        check({name, "_mem_addr"}, mem_addr, addr);
        if (we) check({name, "_mem_wdata"}, mem_wdata, wdata);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check1({name, "_req_held"}, mem_req, 1'b1);
            check({name, "_addr_held"}, mem_addr, addr);
            if (we) begin
                check1({name, "_we_held"}, mem_we, 1'b1);
                check({name, "_wdata_held"}, mem_wdata, wdata);
            end
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic wait_valid(input bit is_fetch, input string name, output int lat);
        lat = 0;
        @(negedge clk);
        while (!(is_fetch ? if_valid : d_valid) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!(is_fetch ? if_valid : d_valid)) begin
            expire({name, "_valid"});
            lat = -1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t_d, t_i, n;

        rst = 1'b1;
        if_req = 0; if_addr = 0; if_kill = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_if_valid", if_valid, 1'b0);
        check1("rst_d_valid", d_valid, 1'b0);
        check1("rst_mem_err", mem_err, 1'b0);
        check1("rst_mem_stall", mem_stall, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);

        // Single read, two wait cycles.
        @(posedge clk); #1;
        sb.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, "read40"});
        d_req = 1; d_we = 0; d_addr = 32'h40;
        serve(2, 32'hDEAD_BEEF, 1'b0, 32'h40, 32'h0, "read40", lat);
        check("read40_issue_lat", lat, 32'd1);
        wait_valid(1'b0, "read40", lat);
        check("read40_resp_lat", lat, 32'd0);
        check1("read40_req_low_in_resp", mem_req, 1'b0);
        @(posedge clk); #1 d_req = 0;
        @(negedge clk);
        check1("read40_single_pulse", d_valid, 1'b0);
        check1("read40_stall_after", mem_stall, 1'b0);
        check1("read40_no_reissue", mem_req, 1'b0);

        // Simultaneous requests: data first, fetch granted in the IDLE after data RESP.
        @(posedge clk); #1;
        sb.push_back('{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, "prio_d"});
        sb.push_back('{1'b0, 32'h1357_9BDF, 1'b1, 1'b0, "prio_i"});
        d_req = 1; d_we = 0; d_addr = 32'h200;
        if_req = 1; if_addr = 32'h4;
        #1 check1("prio_stall", mem_stall, 1'b1);
        serve(0, 32'hA5A5_0001, 1'b0, 32'h200, 32'h0, "prio_d", lat);
        wait_valid(1'b0, "prio_d", lat);
        t_d = cyc;
        @(posedge clk); #1 d_req = 0;
        serve(0, 32'h1357_9BDF, 1'b0, 32'h4, 32'h0, "prio_i", lat);
        check("prio_fetch_issue_lat", lat, 32'd1);
        wait_valid(1'b1, "prio_i", lat);
        t_i = cyc;
        check1("prio_gap_ge3", (t_i - t_d) >= 3, 1'b1);
        @(posedge clk); #1 if_req = 0;

        // Write with three wait cycles; request fields must stay put.
        @(posedge clk); #1;
        sb.push_back('{1'b1, 32'h0, 1'b0, 1'b0, "write100"});
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h1234;
        serve(3, 32'h0BAD_F00D, 1'b1, 32'h100, 32'h1234, "write100", lat);
        wait_valid(1'b0, "write100", lat);
        @(posedge clk); #1 d_req = 0; d_we = 0;
        @(negedge clk);
        check1("write100_single_pulse", d_valid, 1'b0);

        // Kill one cycle before mem_ready; IF moves on to 0xC.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h8;
        wait_mem_req("kill8", lat);
        check("kill8_mem_addr", mem_addr, 32'h8);
        check1("kill8_mem_we", mem_we, 1'b0);
        if_kill = 1; if_addr = 32'hC;
        #1 check1("kill8_stall_drop", mem_stall, 1'b0);
        @(negedge clk);
        if_kill = 0; mem_ready = 1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1 mem_ready = 0;
        @(negedge clk);
        check1("kill8_no_if_valid", if_valid, 1'b0);
        check1("kill8_req_low", mem_req, 1'b0);
        sb.push_back('{1'b0, 32'h0000_C0DE, 1'b1, 1'b0, "fetchC"});
        serve(1, 32'h0000_C0DE, 1'b0, 32'hC, 32'h0, "fetchC", lat);
        wait_valid(1'b1, "fetchC", lat);
        @(posedge clk); #1 if_req = 0;

        // Kill in the same cycle as mem_ready.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h10;
        wait_mem_req("kill10", lat);
        if_kill = 1; mem_ready = 1; mem_rdata = 32'h3333_4444;
        @(posedge clk); #1 mem_ready = 0; if_kill = 0; if_req = 0;
        @(negedge clk);
        check1("kill10_no_if_valid", if_valid, 1'b0);

        // Timeout: ready never comes, stale bus data must not be captured.
        @(posedge clk); #1;
        sb.push_back('{1'b1, 32'h0, 1'b1, 1'b1, "timeout300"});
        mem_rdata = 32'hFFFF_FFFF;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        wait_mem_req("timeout300", lat);
        n = (lat < 0) ? 0 : 1;
        while (mem_req === 1'b1 && n < 20) begin
            @(negedge clk);
            if (mem_req === 1'b1) n++;
        end
        check("timeout_req_cycles", n, 32'd4);
        check1("timeout_d_valid", d_valid, 1'b1);
        check1("timeout_mem_err", mem_err, 1'b1);
        @(posedge clk); #1 d_req = 0;
        @(negedge clk);
        check1("timeout_err_single", mem_err, 1'b0);
        @(posedge clk); #1;
        sb.push_back('{1'b1, 32'h0000_600D, 1'b1, 1'b0, "after_to"});
        d_req = 1; d_addr = 32'h304;
        serve(0, 32'h0000_600D, 1'b0, 32'h304, 32'h0, "after_to", lat);
        check("after_to_issue_lat", lat, 32'd1);
        wait_valid(1'b0, "after_to", lat);
        @(posedge clk); #1 d_req = 0;

        // Asynchronous reset in D_WAIT, then a late mem_ready.
        @(posedge clk); #1;
        d_req = 1; d_addr = 32'h44;
        wait_mem_req("rst44", lat);
        #2 rst = 1'b1;
        #1 check1("rst44_req_async", mem_req, 1'b0);
        d_req = 0;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1; mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("rst44_no_d_valid", d_valid, 1'b0);
            check1("rst44_no_req", mem_req, 1'b0);
        end
        mem_ready = 0;

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
